// File: rtl/div_ctrl_pkg.sv
// Shared CPU defines slice: divide engine and divide issue/retire controller
// state encodings plus small result-field helpers.
package div_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    typedef enum logic [1:0] {
        DIVC_IDLE = 2'b00,
        DIVC_BUSY = 2'b01,
        DIVC_DONE = 2'b10
    } divc_state_e;

    // Engine result packs {remainder, quotient}.
    function automatic logic [DATA_W-1:0] div_res_hi(input logic [2*DATA_W-1:0] res);
        return res[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] div_res_lo(input logic [2*DATA_W-1:0] res);
        return res[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage issue/retire controller for the multi-cycle divide engine: issues
// DIV/DIVU, stalls until the engine succeeds, latches HI/LO, cancels on flush.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                div_op_i,
    input  logic                signed_op_i,
    input  logic [DATA_W-1:0]   opa_i,
    input  logic [DATA_W-1:0]   opb_i,
    input  logic                flush_i,
    input  logic                hold_i,
    output logic                div_start_o,
    output logic                div_cancel_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_dividend_o,
    output logic [DATA_W-1:0]   div_divider_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_success_i,
    output logic                stall_req_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                hilo_valid_o
);

    divc_state_e         state_q, state_d;
    logic                start_q, start_d;
    logic                signed_q, signed_d;
    logic [DATA_W-1:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divider_q, divider_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                valid_q, valid_d;

    // Next-state and next-output computation for the controller FSM.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        signed_d   = signed_q;
        dividend_d = dividend_q;
        divider_d  = divider_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        valid_d    = valid_q;
        case (state_q)
            DIVC_IDLE: begin
                // A still-high success is the previous op's tail: wait it out.
                if (div_op_i && !flush_i && !div_success_i) begin
                    state_d    = DIVC_BUSY;
                    start_d    = 1'b1;
                    signed_d   = signed_op_i;
                    dividend_d = opa_i;
                    divider_d  = opb_i;
                end else begin
                    state_d = DIVC_IDLE;
                    start_d = 1'b0;
                end
                valid_d = 1'b0;
            end
            DIVC_BUSY: begin
                if (flush_i) begin
                    state_d = DIVC_IDLE;
                    start_d = 1'b0;
                    valid_d = 1'b0;
                end else if (div_success_i) begin
                    state_d = DIVC_DONE;
                    start_d = 1'b0;
                    hi_d    = div_res_hi(div_result_i);
                    lo_d    = div_res_lo(div_result_i);
                    valid_d = 1'b1;
                end else begin
                    state_d = DIVC_BUSY;
                    start_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            DIVC_DONE: begin
                start_d = 1'b0;
                if (flush_i || !hold_i) begin
                    state_d = DIVC_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = DIVC_DONE;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = DIVC_IDLE;
                start_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; everything clears on synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIVC_IDLE;
            start_q    <= 1'b0;
            signed_q   <= 1'b0;
            dividend_q <= {DATA_W{1'b0}};
            divider_q  <= {DATA_W{1'b0}};
            hi_q       <= {DATA_W{1'b0}};
            lo_q       <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            signed_q   <= signed_d;
            dividend_q <= dividend_d;
            divider_q  <= divider_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            valid_q    <= valid_d;
        end
    end

    // Stall and cancel must react within the cycle, so they decode state directly.
    always_comb begin
        stall_req_o  = 1'b0;
        div_cancel_o = 1'b0;
        case (state_q)
            DIVC_IDLE: begin
                stall_req_o  = div_op_i && !flush_i;
                div_cancel_o = 1'b0;
            end
            DIVC_BUSY: begin
                stall_req_o  = 1'b1;
                div_cancel_o = flush_i;
            end
            DIVC_DONE: begin
                stall_req_o  = 1'b0;
                div_cancel_o = 1'b0;
            end
            default: begin
                stall_req_o  = 1'b0;
                div_cancel_o = 1'b0;
            end
        endcase
    end

    assign div_start_o    = start_q;
    assign div_signed_o   = signed_q;
    assign div_dividend_o = dividend_q;
    assign div_divider_o  = divider_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign hilo_valid_o   = valid_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural divide engine drives the
// handshake, and results are checked against plain-arithmetic expectations.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_op_i, signed_op_i, flush_i, hold_i;
    logic [31:0] opa_i, opb_i;
    logic        div_start_o, div_cancel_o, div_signed_o;
    logic [31:0] div_dividend_o, div_divider_o;
    logic [63:0] div_result_i;
    logic        div_success_i;
    logic        stall_req_o;
    logic [31:0] hi_o, lo_o;
    logic        hilo_valid_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst),
        .div_op_i(div_op_i), .signed_op_i(signed_op_i),
        .opa_i(opa_i), .opb_i(opb_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
        .div_signed_o(div_signed_o),
        .div_dividend_o(div_dividend_o), .div_divider_o(div_divider_o),
        .div_result_i(div_result_i), .div_success_i(div_success_i),
        .stall_req_o(stall_req_o),
        .hi_o(hi_o), .lo_o(lo_o), .hilo_valid_o(hilo_valid_o)
    );

    // MIPS divide semantics: truncate toward zero, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural engine: FREE -> ON(lat) -> END; success holds until start
    // drops, then lingers tail_cfg extra cycles.
    int          lat_cfg = 5;
    int          tail_cfg = 0;
    int          eng_state, eng_cnt, eng_tail;
    logic [63:0] eng_pend;
    always @(posedge clk) begin
        if (rst) begin
            eng_state     <= 0;
            div_success_i <= 1'b0;
            div_result_i  <= 64'd0;
            eng_cnt       <= 0;
            eng_tail      <= 0;
        end else begin
            case (eng_state)
                0: if (div_start_o && !div_cancel_o) begin
                    eng_pend  <= ref_div(div_dividend_o, div_divider_o, div_signed_o);
                    eng_cnt   <= (div_divider_o == 32'd0) ? 1 : lat_cfg;
                    eng_state <= 1;
                end
                1: if (div_cancel_o) eng_state <= 0;
                   else if (eng_cnt <= 1) begin
                       eng_state     <= 2;
                       div_success_i <= 1'b1;
                       div_result_i  <= eng_pend;
                       eng_tail      <= tail_cfg;
                   end else eng_cnt <= eng_cnt - 1;
                default: if (!div_start_o) begin
                    if (eng_tail == 0) begin
                        eng_state     <= 0;
                        div_success_i <= 1'b0;
                        div_result_i  <= 64'd0;
                    end else eng_tail <= eng_tail - 1;
                end
            endcase
        end
    end

    // Event monitor: start must never rise right after a high success.
    int   cyc = 0, start_cyc = 0, succ_cyc = 0;
    logic prev_start = 1'b0, prev_succ = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (div_start_o && !prev_start) begin
            start_cyc = cyc;
            checks++;
            if (prev_succ) $display("FAIL issue_after_success: start rose at cycle %0d, prior success 1, required 0", cyc);
            else passes++;
        end
        if (div_success_i && !prev_succ) succ_cyc = cyc;
        prev_start = div_start_o;
        prev_succ  = div_success_i;
    end

    typedef struct {
        logic [31:0] hi, lo, opa, opb;
        logic        sgn, done_stall;
        int          stall, valid, exp_stall;
        bit          to;
    } div_obs_t;

    // Present one divide in EX and follow it to retirement.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold_n, input bit chained, output div_obs_t o);
        int n;
        if (!chained) @(negedge clk);
        div_op_i = 1'b1; opa_i = a; opb_i = b; signed_op_i = s; hold_i = 1'b0; flush_i = 1'b0;
        #1;
        o.stall = 0; o.valid = 0; o.to = 1'b0; n = 0;
        while (!hilo_valid_o && !o.to) begin
            if (stall_req_o) o.stall++;
            @(negedge clk); #1;
            n++;
            if (n > 400) o.to = 1'b1;
        end
        o.hi = hi_o; o.lo = lo_o; o.done_stall = stall_req_o;
        o.opa = div_dividend_o; o.opb = div_divider_o; o.sgn = div_signed_o;
        o.exp_stall = succ_cyc - start_cyc + 2;
        while (hilo_valid_o && o.valid < 32) begin
            o.valid++;
            hold_i = (o.valid <= hold_n);
            @(negedge clk); #1;
        end
        hold_i = 1'b0; div_op_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [132:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        outs = {div_start_o, div_cancel_o, div_signed_o, div_dividend_o, div_divider_o,
                stall_req_o, hi_o, lo_o, hilo_valid_o};
        checks++;
        if (outs !== 133'd0) $display("FAIL reset_outputs: got %h required 0", outs);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_idle_flush();
        @(negedge clk);
        div_op_i = 1'b1; flush_i = 1'b1; opa_i = 32'd9; opb_i = 32'd3; signed_op_i = 1'b0;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) $display("FAIL idle_flush_stall: got %b required 0", stall_req_o);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (div_start_o !== 1'b0) $display("FAIL idle_flush_no_issue: got %b required 0", div_start_o);
        else passes++;
        div_op_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_signed_100_7();
        div_obs_t o;
        lat_cfg = 6; tail_cfg = 0;
        do_div(32'd100, 32'd7, 1'b1, 0, 1'b0, o);
        checks++;
        if (o.to || o.lo !== 32'h0000000E || o.hi !== 32'h00000002)
            $display("FAIL div100_7: got hi=%h lo=%h to=%0d required hi=00000002 lo=0000000e", o.hi, o.lo, o.to);
        else passes++;
        checks++;
        if (o.valid !== 1) $display("FAIL div100_7_valid_len: got %0d required 1", o.valid);
        else passes++;
        checks++;
        if (o.done_stall !== 1'b0) $display("FAIL div100_7_done_stall: got %b required 0", o.done_stall);
        else passes++;
        checks++;
        if (o.stall !== o.exp_stall) $display("FAIL div100_7_stall_len: got %0d required %0d", o.stall, o.exp_stall);
        else passes++;
        checks++;
        if ({o.sgn, o.opa, o.opb} !== {1'b1, 32'd100, 32'd7})
            $display("FAIL div100_7_operands: got %b %h %h required 1 00000064 00000007", o.sgn, o.opa, o.opb);
        else passes++;
    endtask

    task automatic test_neg7_2();
        div_obs_t o;
        lat_cfg = 9;
        do_div(32'hFFFFFFF9, 32'h2, 1'b1, 0, 1'b0, o);
        checks++;
        if (o.to || o.lo !== 32'hFFFFFFFD || o.hi !== 32'hFFFFFFFF)
            $display("FAIL sdiv_m7_2: got hi=%h lo=%h required hi=ffffffff lo=fffffffd", o.hi, o.lo);
        else passes++;
        do_div(32'hFFFFFFF9, 32'h2, 1'b0, 0, 1'b0, o);
        checks++;
        if (o.to || o.lo !== 32'h7FFFFFFC || o.hi !== 32'h00000001)
            $display("FAIL udiv_fff9_2: got hi=%h lo=%h required hi=00000001 lo=7ffffffc", o.hi, o.lo);
        else passes++;
    endtask

    task automatic test_div_zero();
        div_obs_t o;
        lat_cfg = 30;
        do_div(32'd5, 32'd0, 1'b1, 0, 1'b0, o);
        checks++;
        if (o.to || o.hi !== 32'd0 || o.lo !== 32'd0 || o.valid !== 1)
            $display("FAIL div_by_zero: got hi=%h lo=%h valid=%0d to=%0d required 0 0 1 0", o.hi, o.lo, o.valid, o.to);
        else passes++;
        checks++;
        if (o.stall > 6) $display("FAIL div_by_zero_latency: got %0d stall cycles required at most 6", o.stall);
        else passes++;
    endtask

    task automatic test_flush();
        div_obs_t o;
        int   n;
        logic seen_valid;
        lat_cfg = 34; tail_cfg = 0; seen_valid = 1'b0; n = 0;
        @(negedge clk);
        div_op_i = 1'b1; opa_i = 32'd1000; opb_i = 32'd3; signed_op_i = 1'b0;
        #1;
        while (!div_start_o && n < 10) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); #1;
            if (hilo_valid_o) seen_valid = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        checks++;
        if (div_cancel_o !== 1'b1) $display("FAIL flush_cancel_pulse: got %b required 1", div_cancel_o);
        else passes++;
        @(negedge clk);
        flush_i = 1'b0; opa_i = 32'd12345; opb_i = 32'd17;
        #1;
        checks++;
        if ({div_cancel_o, div_start_o, hilo_valid_o, seen_valid} !== 4'b0000)
            $display("FAIL flush_after: got cancel/start/valid/seen=%b required 0000", {div_cancel_o, div_start_o, hilo_valid_o, seen_valid});
        else passes++;
        lat_cfg = 8;
        do_div(32'd12345, 32'd17, 1'b0, 0, 1'b1, o);
        checks++;
        if (o.to || {o.hi, o.lo} !== {32'd3, 32'd726})
            $display("FAIL flush_reissue: got hi=%h lo=%h required hi=00000003 lo=000002d6", o.hi, o.lo);
        else passes++;
    endtask

    task automatic test_back_to_back();
        div_obs_t o1, o2;
        lat_cfg = 7; tail_cfg = 5;
        do_div(32'd4000, 32'd33, 1'b0, 3, 1'b0, o1);
        tail_cfg = 0;
        do_div(32'hFFFFF000, 32'd10, 1'b1, 0, 1'b1, o2);
        checks++;
        if (o1.valid !== 4) $display("FAIL b2b_hold_valid_len: got %0d required 4", o1.valid);
        else passes++;
        checks++;
        if (o1.to || {o1.hi, o1.lo} !== {32'd7, 32'd121})
            $display("FAIL b2b_first: got hi=%h lo=%h required hi=00000007 lo=00000079", o1.hi, o1.lo);
        else passes++;
        checks++;
        if (o2.to || {o2.hi, o2.lo} !== {32'hFFFFFFFA, 32'hFFFFFE67})
            $display("FAIL b2b_second: got hi=%h lo=%h required hi=fffffffa lo=fffffe67", o2.hi, o2.lo);
        else passes++;
        checks++;
        if (o2.stall <= o2.exp_stall)
            $display("FAIL b2b_tail_wait: got %0d stall cycles required more than %0d", o2.stall, o2.exp_stall);
        else passes++;
    endtask

    task automatic test_reset_mid_busy();
        div_obs_t     o;
        logic [132:0] outs;
        lat_cfg = 30;
        @(negedge clk);
        div_op_i = 1'b1; opa_i = 32'd55555; opb_i = 32'hFFFFFFFD; signed_op_i = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; div_op_i = 1'b0;
        @(negedge clk); #1;
        outs = {div_start_o, div_cancel_o, div_signed_o, div_dividend_o, div_divider_o,
                stall_req_o, hi_o, lo_o, hilo_valid_o};
        checks++;
        if (outs !== 133'd0) $display("FAIL reset_mid_busy: got %h required 0", outs);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        lat_cfg = 4;
        do_div(32'd77, 32'd5, 1'b0, 0, 1'b0, o);
        checks++;
        if (o.to || {o.hi, o.lo} !== {32'd2, 32'd15})
            $display("FAIL post_reset_div: got hi=%h lo=%h required hi=00000002 lo=0000000f", o.hi, o.lo);
        else passes++;
    endtask

    task automatic test_random();
        div_obs_t    o;
        logic [31:0] a, b;
        logic        s;
        int          hold_n, prev_tail;
        bit          chained;
        prev_tail = 0;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            s = 1'($urandom_range(0, 1));
            if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            hold_n  = $urandom_range(0, 2);
            chained = 1'($urandom_range(0, 1));
            lat_cfg = $urandom_range(1, 40);
            tail_cfg = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            do_div(a, b, s, hold_n, chained, o);
            checks++;
            if (o.to || {o.hi, o.lo} !== ref_div(a, b, s))
                $display("FAIL rand_result[%0d]: a=%h b=%h s=%b got %h%h required %h", i, a, b, s, o.hi, o.lo, ref_div(a, b, s));
            else passes++;
            checks++;
            if (o.valid !== hold_n + 1 || o.done_stall !== 1'b0)
                $display("FAIL rand_retire[%0d]: got valid_len=%0d done_stall=%b required %0d 0", i, o.valid, o.done_stall, hold_n + 1);
            else passes++;
            checks++;
            if ({o.sgn, o.opa, o.opb} !== {s, a, b})
                $display("FAIL rand_operands[%0d]: got %b %h %h required %b %h %h", i, o.sgn, o.opa, o.opb, s, a, b);
            else passes++;
            if (prev_tail == 0) begin
                checks++;
                if (o.stall !== o.exp_stall) $display("FAIL rand_stall_len[%0d]: got %0d required %0d", i, o.stall, o.exp_stall);
                else passes++;
            end
            prev_tail = tail_cfg;
        end
    endtask

    initial begin
        rst = 1'b1; div_op_i = 1'b0; signed_op_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        opa_i = 32'd0; opb_i = 32'd0;
        test_reset();
        test_idle_flush();
        test_signed_100_7();
        test_neg7_2();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
